// File: rtl/lab4_mem_responder.sv
// lab4_mem_responder: backing memory for the lab4 cache controller; fixed-latency
// line-read bursts and single-word writes with an echo ack beat.
module lab4_mem_responder #(
  parameter int ADDR_BITS  = 8,
  parameter int LATENCY    = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic        gclk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_data,
  output logic        mem_valid,
  output logic        mem_busy
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int BW    = $clog2(LINE_WORDS) + 1;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT} state_t;
  typedef logic [DEPTH-1:0][31:0] mem_t;
  function automatic mem_t f_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = 32'hA000_0000 | 32'(i);
    return m;
  endfunction
  mem_t                 r_mem = f_init();
  state_t               r_state, w_state_nx;
  logic [3:0]           r_lat, w_lat_nx;
  logic [BW-1:0]        r_beat, w_beat_nx;
  logic [ADDR_BITS-1:0] r_base, w_base_nx;
  logic [31:0]          r_data, w_data_nx;
  logic                 r_valid, w_valid_nx, w_we;
  logic [ADDR_BITS-1:0] w_idx, w_line;
  logic                 w_unused;
  assign w_idx     = mem_addr[ADDR_BITS+1:2];
  assign w_line    = w_idx & ~ADDR_BITS'(LINE_WORDS - 1);
  assign w_unused  = ^{mem_addr[31:ADDR_BITS+2], mem_addr[1:0]};
  assign mem_data  = r_data;
  assign mem_valid = r_valid;
  assign mem_busy  = r_state != IDLE;
  always_comb begin
    w_state_nx = r_state;
    w_lat_nx   = r_lat;
    w_beat_nx  = r_beat;
    w_base_nx  = r_base;
    w_data_nx  = r_data;
    w_valid_nx = 1'b0;
    w_we       = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_rd) begin
          w_state_nx = RD_WAIT;
          w_lat_nx   = 4'(LATENCY);
          w_beat_nx  = '0;
          w_base_nx  = w_line;
        end else if (mem_we) begin
          w_state_nx = WR_WAIT;
          w_lat_nx   = 4'(LATENCY);
          w_beat_nx  = '0;
          w_base_nx  = w_idx;
          w_we       = 1'b1;
        end
      end
      RD_WAIT: begin
        w_lat_nx = r_lat - 4'd1;
        if (r_lat == 4'd1) begin
          w_state_nx = RD_BURST;
          w_valid_nx = 1'b1;
          w_data_nx  = r_mem[r_base];
          w_beat_nx  = BW'(1);
        end
      end
      RD_BURST: begin
        if (r_beat == BW'(LINE_WORDS)) begin
          w_state_nx = IDLE;
        end else begin
          w_valid_nx = 1'b1;
          w_data_nx  = r_mem[r_base + ADDR_BITS'(r_beat)];
          w_beat_nx  = r_beat + BW'(1);
        end
      end
      WR_WAIT: begin
        // the word was stored at accept, so the ack echoes it straight from the array
        w_lat_nx   = r_lat == 4'd0 ? r_lat : r_lat - 4'd1;
        w_state_nx = r_lat == 4'd0 ? IDLE : WR_WAIT;
        w_valid_nx = r_lat == 4'd1;
        w_data_nx  = r_lat == 4'd1 ? r_mem[r_base] : r_data;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_lat   <= '0;
      r_beat  <= '0;
      r_base  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_lat   <= w_lat_nx;
      r_beat  <= w_beat_nx;
      r_base  <= w_base_nx;
      r_data  <= w_data_nx;
      r_valid <= w_valid_nx;
    end
  end
  always_ff @(posedge gclk) begin
    if (w_we && !rst) r_mem[w_idx] <= mem_wdata;
  end
endmodule
